// File: rtl/dso_pkg.sv
// Shared constants and FSM state type for the SPI slave and its synchronizers.
package dso_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = $clog2(FRAME_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Bundle of the SPI pad signals and the host-side command/response signals.
interface spi_slave_if;
  import dso_pkg::*;

  logic                  SS_n;
  logic                  SCLK;
  logic                  MOSI;
  logic                  MISO;
  logic                  MISO_oe;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  wrt;
  logic [FRAME_BITS-1:0] cmd;
  logic                  rdy;
  logic                  clr_rdy;
  logic                  ovr;

  // cmd is valid while rdy is high; clr_rdy is the consumer's one-clk ack and
  // rdy drops on the following clk. A frame landing while rdy is still high
  // overwrites cmd and raises ovr, which stays set until the next clr_rdy.
  modport master (
    output SS_n, SCLK, MOSI, tx_data, wrt, clr_rdy,
    input  MISO, MISO_oe, cmd, rdy, ovr
  );

  modport slave (
    input  SS_n, SCLK, MOSI, tx_data, wrt, clr_rdy,
    output MISO, MISO_oe, cmd, rdy, ovr
  );

endinterface

// File: rtl/spi_sync3.sv
// Two-flop synchronizer followed by one history flop for edge detection.
module spi_sync3
  import dso_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES:0] sync_q;
  logic [SYNC_STAGES:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-1:0], async_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {(SYNC_STAGES + 1){RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Top bit is the previous synchronized value.
  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
  assign fall_o = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave: oversamples SS_n/SCLK/MOSI in the clk domain and exchanges
// 16-bit frames, presenting received words on cmd/rdy with a sticky overrun.
module spi_slave
  import dso_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_oe,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  wrt,
  output logic [FRAME_BITS-1:0] cmd,
  output logic                  rdy,
  input  logic                  clr_rdy,
  output logic                  ovr
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] rx_shft_q, rx_shft_d;
  logic [FRAME_BITS-1:0] tx_shft_q, tx_shft_d;
  logic [FRAME_BITS-1:0] tx_buf_q, tx_buf_d;
  logic [FRAME_BITS-1:0] cmd_q, cmd_d;
  logic                  rdy_q, rdy_d;
  logic                  ovr_q, ovr_d;
  logic                  done_q, done_d;

  logic ss_rise, ss_fall;
  logic sclk_rise, sclk_fall;
  logic mosi_s;
  logic ss_sync_unused, sclk_sync_unused, mosi_rise_unused, mosi_fall_unused;

  logic start, frame_end, rx_en, tx_en;

  spi_sync3 #(.RST_VAL(1'b1)) u_sync_ss (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(SS_n),
    .sync_o (ss_sync_unused),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync3 #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(SCLK),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync3 #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(MOSI),
    .sync_o (mosi_s),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ss_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (ss_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The counter saturating at FRAME_BITS is what makes extra SCLK rises inert.
  always_comb begin
    start     = 1'b0;
    frame_end = 1'b0;
    rx_en     = 1'b0;
    tx_en     = 1'b0;
    MISO      = 1'b0;
    MISO_oe   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start = ss_fall;
      end
      ST_SHIFT: begin
        MISO_oe   = 1'b1;
        MISO      = tx_shft_q[FRAME_BITS-1];
        frame_end = ss_rise;
        rx_en     = sclk_rise && (cnt_q < CNT_FULL);
        tx_en     = sclk_fall && (cnt_q != '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start || frame_end) begin
      cnt_d = '0;
    end else if (rx_en) begin
      cnt_d = cnt_q + 1'b1;
    end

    rx_shft_d = rx_en ? {rx_shft_q[FRAME_BITS-2:0], mosi_s} : rx_shft_q;

    tx_shft_d = tx_shft_q;
    if (start) begin
      tx_shft_d = tx_buf_q;
    end else if (tx_en) begin
      tx_shft_d = {tx_shft_q[FRAME_BITS-2:0], 1'b0};
    end

    // tx_shft is only reloaded at frame start, so a mid-frame wrt waits a frame.
    tx_buf_d = wrt ? tx_data : tx_buf_q;
    done_d   = rx_en && (cnt_q == CNT_LAST);
    cmd_d    = done_q ? rx_shft_q : cmd_q;

    rdy_d = rdy_q;
    if (done_q) begin
      rdy_d = 1'b1;
    end else if (clr_rdy) begin
      rdy_d = 1'b0;
    end

    ovr_d = ovr_q;
    if (clr_rdy) begin
      ovr_d = 1'b0;
    end else if (done_q && rdy_q) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rx_shft_q <= '0;
      tx_shft_q <= '0;
      tx_buf_q  <= '0;
      cmd_q     <= '0;
      rdy_q     <= 1'b0;
      ovr_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rx_shft_q <= rx_shft_d;
      tx_shft_q <= tx_shft_d;
      tx_buf_q  <= tx_buf_d;
      cmd_q     <= cmd_d;
      rdy_q     <= rdy_d;
      ovr_q     <= ovr_d;
      done_q    <= done_d;
    end
  end

  assign cmd = cmd_q;
  assign rdy = rdy_q;
  assign ovr = ovr_q;

endmodule
